// File: rtl/ppt_pulse_engine.sv
// ============================================================================
// Module   : ppt_pulse_engine
// Purpose  : Prescaled pulse-train generator driving the PPT fire line.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ppt_pulse_engine #(
  parameter int PRESC_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  clk_div,
  input  logic [15:0] period,
  input  logic [15:0] width,
  input  logic [7:0]  count,
  input  logic        run_ppt,
  output logic        ppt_fire,
  output logic [7:0]  count_done,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           clk_div_q, clk_div_d;
  logic [15:0]          period_q, period_d;
  logic [15:0]          width_q, width_d;
  logic [7:0]           count_q, count_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   presc_max;
  logic [15:0]          phase_q, phase_d;
  logic [15:0]          phase_inc;
  logic [7:0]           count_done_q, count_done_d;
  logic [7:0]           count_done_inc;
  logic                 ppt_fire_q, ppt_fire_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  // Terminal prescaler value 2^(clk_div+1)-1; a shift of the full width yields all ones.
  assign presc_max = ~({PRESC_W{1'b1}} << ({1'b0, clk_div_q} + 6'd1));

  always_comb begin
    state_d        = state_q;
    clk_div_d      = clk_div_q;
    period_d       = period_q;
    width_d        = width_q;
    count_d        = count_q;
    presc_d        = presc_q;
    phase_d        = phase_q;
    count_done_d   = count_done_q;
    ppt_fire_d     = ppt_fire_q;
    done_d         = done_q;
    tick           = 1'b0;
    phase_inc      = phase_q + 16'd1;
    count_done_inc = count_done_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (run_ppt) begin
          clk_div_d    = clk_div;
          period_d     = period;
          width_d      = width;
          count_d      = count;
          count_done_d = 8'd0;
          done_d       = 1'b0;
          presc_d      = '0;
          phase_d      = 16'd0;
          if ((count == 8'd0) || (period == 16'd0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (width != 16'd0) begin
            state_d    = S_PULSE;
            ppt_fire_d = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_PULSE, S_GAP: begin
        if (!run_ppt) begin
          state_d    = S_IDLE;
          ppt_fire_d = 1'b0;
        end else begin
          tick    = (presc_q == presc_max);
          presc_d = tick ? '0 : presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
          if (tick) begin
            // Period end outranks the pulse-end test so width >= period never sees a GAP tick.
            if (phase_q == period_q - 16'd1) begin
              phase_d      = 16'd0;
              count_done_d = count_done_inc;
              if (count_done_inc == count_q) begin
                state_d    = S_DONE;
                done_d     = 1'b1;
                ppt_fire_d = 1'b0;
              end else if (width_q != 16'd0) begin
                state_d    = S_PULSE;
                ppt_fire_d = 1'b1;
              end else begin
                state_d    = S_GAP;
                ppt_fire_d = 1'b0;
              end
            end else begin
              phase_d = phase_inc;
              if ((state_q == S_PULSE) && (phase_inc == width_q)) begin
                state_d    = S_GAP;
                ppt_fire_d = 1'b0;
              end
            end
          end
        end
      end

      S_DONE: begin
        ppt_fire_d = 1'b0;
        if (!run_ppt) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        ppt_fire_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_PULSE) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clk_div_q    <= 5'd0;
      period_q     <= 16'd0;
      width_q      <= 16'd0;
      count_q      <= 8'd0;
      presc_q      <= '0;
      phase_q      <= 16'd0;
      count_done_q <= 8'd0;
      ppt_fire_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_div_q    <= clk_div_d;
      period_q     <= period_d;
      width_q      <= width_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      count_done_q <= count_done_d;
      ppt_fire_q   <= ppt_fire_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign ppt_fire   = ppt_fire_q;
  assign count_done = count_done_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ppt_pulse_engine.sv
// ============================================================================
// Module   : tb_ppt_pulse_engine
// Purpose  : Self-checking bench for ppt_pulse_engine against a tick-count model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ppt_pulse_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  clk_div = 5'd9;
  logic [15:0] period = 16'd128;
  logic [15:0] width = 16'd1;
  logic [7:0]  count = 8'd16;
  logic        run_ppt = 1'b1;
  logic        ppt_fire;
  logic [7:0]  count_done;
  logic        done;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  ppt_pulse_engine #(.PRESC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_ppt),
    .ppt_fire   (ppt_fire),
    .count_done (count_done),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is a sequence of cycles k=1,2,...; ticks completed by cycle k
  // is (k-1)/2^(clk_div+1), from which period index and phase follow directly.
  int          m_mode = 0;   // 0 idle, 1 running, 2 finished
  longint      m_k    = 0;
  logic [4:0]  s_cd   = '0;
  logic [15:0] s_per  = '0;
  logic [15:0] s_wid  = '0;
  logic [7:0]  s_cnt  = '0;
  logic        e_fire = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic [7:0]  e_cd   = '0;

  task automatic model_step();
    longint tick_len, n, p, ph;
    m_k++;
    tick_len = longint'(1) << (s_cd + 1);
    n  = (m_k - 1) / tick_len;
    p  = n / s_per;
    ph = n % s_per;
    if (p >= s_cnt) begin
      m_mode = 2;
      e_done = 1'b1;
      e_cd   = s_cnt;
      e_fire = 1'b0;
      e_busy = 1'b0;
    end else begin
      e_cd   = 8'(p);
      e_fire = (ph < s_wid);
      e_busy = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = 0;
        e_fire = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_cd   = 8'd0;
      end else begin
        case (m_mode)
          0: if (run_ppt) begin
            s_cd   = clk_div;
            s_per  = period;
            s_wid  = width;
            s_cnt  = count;
            m_k    = 0;
            e_cd   = 8'd0;
            e_done = 1'b0;
            if ((count == 8'd0) || (period == 16'd0)) begin
              m_mode = 2;
              e_done = 1'b1;
              e_fire = 1'b0;
              e_busy = 1'b0;
            end else begin
              m_mode = 1;
              model_step();
            end
          end
          1: if (!run_ppt) begin
            m_mode = 0;
            e_fire = 1'b0;
            e_busy = 1'b0;
          end else begin
            model_step();
          end
          default: if (!run_ppt) m_mode = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_fire",       ppt_fire,   e_fire);
      chk("model_busy",       busy,       e_busy);
      chk("model_done",       done,       e_done);
      chk("model_count_done", count_done, e_cd);
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int cd, input int per, input int wid, input int cnt);
    clk_div = 5'(cd);
    period  = 16'(per);
    width   = 16'(wid);
    count   = 8'(cnt);
  endtask

  initial begin
    int dur;
    go(3);
    chk("reset_fire",       ppt_fire,   1'b0);
    chk("reset_busy",       busy,       1'b0);
    chk("reset_done",       done,       1'b0);
    chk("reset_count_done", count_done, 8'd0);

    // Reset defaults with run held: 1024-cycle pulse at cycle 1.
    rst = 1'b0;
    go(1);    chk("def_fire_c1",    ppt_fire, 1'b1);
    go(1023); chk("def_fire_c1024", ppt_fire, 1'b1);
    go(1);    chk("def_fire_c1025", ppt_fire, 1'b0);
    run_ppt = 1'b0; go(2);

    // Basic train, with a config write mid-run that must be ignored.
    set_cfg(0, 4, 1, 3); run_ppt = 1'b1;
    go(1); chk("a_fire_c1", ppt_fire, 1'b1);
    go(1); chk("a_fire_c2", ppt_fire, 1'b1);
    go(1); chk("a_fire_c3", ppt_fire, 1'b0);
    go(6); chk("a_fire_c9", ppt_fire, 1'b1);
    set_cfg(0, 8, 3, 3);
    go(15); chk("a_done_c24", done, 1'b0);
    go(1);  chk("a_done_c25", done, 1'b1); chk("a_cd_c25", count_done, 8'd3);
    go(10); chk("a_hold_fire", ppt_fire, 1'b0);
    run_ppt = 1'b0; go(2);

    // Next run picks up width=3, period=8.
    run_ppt = 1'b1;
    go(6);  chk("b_fire_c6",  ppt_fire, 1'b1);
    go(1);  chk("b_fire_c7",  ppt_fire, 1'b0);
    go(10); chk("b_fire_c17", ppt_fire, 1'b1);
    run_ppt = 1'b0; go(2);

    // Abort at cycle 12, then restart.
    set_cfg(0, 4, 1, 3); run_ppt = 1'b1;
    go(12); run_ppt = 1'b0;
    go(1); chk("ab_fire", ppt_fire, 1'b0); chk("ab_busy", busy, 1'b0);
    chk("ab_cd", count_done, 8'd1); chk("ab_done", done, 1'b0);
    run_ppt = 1'b1;
    go(1); chk("ab_restart_cd", count_done, 8'd0); chk("ab_restart_fire", ppt_fire, 1'b1);
    run_ppt = 1'b0; go(2);

    // count=0 and period=0.
    set_cfg(0, 4, 1, 0); run_ppt = 1'b1;
    go(1); chk("c0_fire", ppt_fire, 1'b0);
    go(1); chk("c0_done", done, 1'b1); chk("c0_busy", busy, 1'b0);
    run_ppt = 1'b0; go(2);
    set_cfg(0, 0, 1, 3); run_ppt = 1'b1;
    go(2); chk("p0_done", done, 1'b1);
    run_ppt = 1'b0; go(2);

    // width=0: periods counted, no fire.
    set_cfg(0, 2, 0, 2); run_ppt = 1'b1;
    go(8); chk("w0_done_c8", done, 1'b0);
    go(1); chk("w0_done_c9", done, 1'b1); chk("w0_cd", count_done, 8'd2);
    run_ppt = 1'b0; go(2);

    // width > period: continuous fire for 3*count ticks.
    set_cfg(0, 3, 5, 2); run_ppt = 1'b1;
    go(12); chk("wp_fire_c12", ppt_fire, 1'b1);
    go(1);  chk("wp_fire_c13", ppt_fire, 1'b0); chk("wp_done", done, 1'b1);
    run_ppt = 1'b0; go(2);

    // Asynchronous reset mid-pulse, then a fresh train.
    set_cfg(1, 4, 2, 5); run_ppt = 1'b1;
    go(3);
    #2 rst = 1'b1;
    #1;
    chk("ar_fire", ppt_fire, 1'b0); chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);     chk("ar_cd", count_done, 8'd0);
    @(negedge clk); rst = 1'b0;
    go(1); chk("ar_restart_fire", ppt_fire, 1'b1); chk("ar_restart_busy", busy, 1'b1);
    run_ppt = 1'b0; go(2);

    // Randomized runs with random aborts, holds and mid-run config writes.
    for (int r = 0; r < 40; r++) begin
      set_cfg($urandom_range(0, 2),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6),
              $urandom_range(0, 7), $urandom_range(0, 5));
      run_ppt = 1'b1;
      dur = $urandom_range(1, 200);
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0)
          set_cfg($urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(0, 7),
                  $urandom_range(0, 5));
      end
      run_ppt = 1'b0;
      go($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ppt_pulse_engine.md
Name: ppt_pulse_engine

Overview:
Pulse-train generator for the PPT (pulsed plasma thruster) firing chain. It sits directly downstream of the I2C register map. It consumes the clk_div, period, width, count and run_ppt configuration and drives the thruster fire output. It returns count_done and done to the register map for status readback.

Parameters:
PRESC_W, 32, width of the prescaler counter. It must be at least 32 so that it can count to 2^(clk_div+1)-1 for clk_div=31.

Ports:
clk  input  1  system clock (32.768 kHz oscillator in the reference build)
rst  input  1  asynchronous, active-high reset
clk_div  input  5  tick rate = f_clk / 2^(clk_div+1)
period  input  16  firing period, in ticks
width  input  16  fire pulse high time, in ticks
count  input  8  number of firings per run
run_ppt  input  1  level enable; high = run, low = abort/idle
ppt_fire  output  1  registered thruster fire pulse
count_done  output  8  firings completed in the current or last run
done  output  1  high when the programmed count has completed
busy  output  1  high in the PULSE or GAP state

Behaviour:
- Clocking and reset: single clock clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: ppt_fire=0, count_done=0, done=0, busy=0, state=IDLE. The prescaler, phase counter and configuration shadows are all 0.
- States: IDLE, PULSE, GAP, DONE.
- IDLE:
  - If run_ppt=1, the block latches clk_div, period, width and count into shadow registers. It clears count_done and done, and zeroes the prescaler and phase.
  - If the latched count==0 or period==0, the next state is DONE and done=1 on the next cycle.
  - Otherwise the next state is PULSE if width!=0, else GAP.
- Latency: ppt_fire rises on the cycle after the cycle in which IDLE samples run_ppt=1.
- Configuration changes while busy are ignored. Shadows are only reloaded in IDLE.
- Tick generation:
  - The prescaler increments every cycle while busy.
  - When it equals 2^(clk_div_s+1)-1, a one-cycle tick fires and the prescaler wraps to 0.
  - One tick therefore spans 2^(clk_div_s+1) clk cycles.
- Phase counter (16 bit): increments on each tick and counts 0..period_s-1.
- PULSE state:
  - ppt_fire=1.
  - On the tick that makes phase reach width_s, go to GAP.
  - If width_s >= period_s, the pulse lasts the full period and the state goes directly to the period-end handling, with no GAP tick.
- GAP state: ppt_fire=0.
- Period end: on the tick where phase==period_s-1:
  - phase wraps to 0 and count_done increments.
  - If the new count_done==count_s, go to DONE with done=1 and ppt_fire=0.
  - Otherwise go to PULSE, or stay in GAP if width_s==0.
  - count_done and done update in the same cycle.
- DONE state:
  - ppt_fire=0, busy=0, done=1.
  - It holds until run_ppt=0, then goes to IDLE.
  - done and count_done stay valid in IDLE until the next start.
  - A run_ppt held high never retriggers.
- Abort: run_ppt=0 while in PULSE or GAP returns the block to IDLE on the next cycle.
  - ppt_fire=0 on that edge.
  - done stays 0 and count_done keeps the firings completed so far.
- Duty-cycle boundaries:
  - width_s=0 gives zero fire pulses, but periods are still counted and done still asserts.
  - period_s=1 with width_s>=1 holds ppt_fire high continuously for count_s ticks.
- Arithmetic: count_done never exceeds count_s (max 255), so no wrap is possible. The phase counter compares against period_s-1 with period_s >= 1 guaranteed.
- Reset mid-run: all state returns to reset values immediately and asynchronously, and ppt_fire drops at once.

Test Plan:
- Reset defaults (clk_div=9, period=128, width=1, count=16, run_ppt=1), then deassert rst -> ppt_fire high for 1024 cycles every 131072 cycles. After 16 periods (2097152 cycles) expect done=1 and count_done=16.
- clk_div=0, period=4, width=1, count=3, pulse run_ppt high -> ppt_fire high 2 cycles out of every 8. Expect pulses starting at cycles +1, +9, +17. done=1 with count_done=3 after 24 cycles, and no further pulses while run_ppt stays high.
- Same configuration, drop run_ppt at cycle 12 -> ppt_fire=0 next cycle, state IDLE, count_done=1, done=0. Reassert run_ppt -> count_done clears and a new 3-pulse train starts.
- Write width=3 and period=8 mid-run while running period=4, width=1 -> current train unchanged. The next run uses the new values: 6 cycles high, 16-cycle period.
- Edge cases:
  - count=0 or period=0 -> done=1 on the second cycle after run_ppt with no fire.
  - width=0, period=2, count=2 -> no fire, done after 8 cycles.
  - width=5, period=3 -> ppt_fire continuously high for 3*count ticks.
- Assert rst mid-PULSE -> ppt_fire, busy, done and count_done are 0 immediately without a clock edge. After release with run_ppt=1, a fresh train starts.
